pwm_timer_channels: RTL

Multi-channel PWM generator directly downstream of the clock divider `CLK_Division`, running entirely in the `ref_clk` domain. It converts the divider's `Div_Clk` into a one-cycle count tick and advances a shared period counter on that tick. Per-channel double-buffered duty compares drive `NUM_CH` PWM outputs, and new settings are reloaded glitch-free at period boundaries.

---
 rtl/pwm_timer_pkg.sv | 13 +
 rtl/pwm_channel_cmp.sv | 64 ++++++
 rtl/pwm_timer_channels.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared state type and default sizing for the multi-channel PWM timer.
package pwm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

    localparam int PWM_NUM_CH = 32'd4;
    localparam int PWM_CNT_W  = 32'd16;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty, compare against the shared counter,
// enable/polarity shaping and the registered output.
module pwm_channel_cmp
    import pwm_timer_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             duty_wr,
    input  logic [CNT_W-1:0] duty_data,
    input  logic             reload,
    input  logic             running,
    input  logic [CNT_W-1:0] cnt,
    input  logic             ch_en,
    input  logic             polarity,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_shadow_r;
    logic [CNT_W-1:0] duty_act_r;
    logic             raw_s;
    logic             pwm_out_r;

    // Shadow register takes host writes at any time.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            duty_shadow_r <= {CNT_W{1'b0}};
        end else if (duty_wr) begin
            duty_shadow_r <= duty_data;
        end
    end

    // Active duty changes only on reload, so a period never sees a half-applied value.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            duty_act_r <= {CNT_W{1'b0}};
        end else if (reload) begin
            duty_act_r <= duty_shadow_r;
        end
    end

    // Active level while the counter is below the duty; duty above period saturates to 100%.
    always_comb begin
        raw_s = 1'b0;
        if (running && ch_en && (cnt < duty_act_r)) begin
            raw_s = 1'b1;
        end else begin
            raw_s = 1'b0;
        end
    end

    // Output register applies polarity so the pin is glitch-free.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            pwm_out_r <= 1'b0;
        end else begin
            pwm_out_r <= raw_s ^ polarity;
        end
    end

    assign pwm_out = pwm_out_r;

endmodule

// File: rtl/pwm_timer_channels.sv
// Multi-channel PWM timer: turns the divider output into a count tick, runs the
// shared period counter and fans the compare out to NUM_CH channels.
module pwm_timer_channels
    import pwm_timer_pkg::*;
#(
    parameter int NUM_CH = PWM_NUM_CH,
    parameter int CNT_W  = PWM_CNT_W
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              clk_En,
    input  logic              Div_Clk,
    input  logic              timer_En,
    input  logic              period_wr,
    input  logic [CNT_W-1:0]  period_data,
    input  logic [NUM_CH-1:0] duty_wr,
    input  logic [CNT_W-1:0]  duty_data,
    input  logic [NUM_CH-1:0] ch_En,
    input  logic [NUM_CH-1:0] polarity,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_done,
    output logic [CNT_W-1:0]  cnt_value
);

    pwm_state_t       state_r;
    pwm_state_t       state_nx_s;
    logic             div_q_r;
    logic             tick_s;
    logic             load_s;
    logic             running_s;
    logic             wrap_s;
    logic             reload_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_sh_r;
    logic [CNT_W-1:0] period_act_r;
    logic             period_done_r;

    // Delayed divider output for rising-edge detection.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            div_q_r <= 1'b0;
        end else begin
            div_q_r <= Div_Clk;
        end
    end

    // With the divider bypassed every ref_clk cycle counts.
    always_comb begin
        tick_s = 1'b0;
        if (clk_En) begin
            tick_s = Div_Clk & ~div_q_r;
        end else begin
            tick_s = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; dropping timer_En always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (timer_En) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (timer_En) begin
                    state_nx_s = RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (timer_En) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    assign running_s = (state_r == RUN);
    assign wrap_s    = running_s & timer_En & tick_s & (cnt_r == period_act_r);
    assign reload_s  = load_s | wrap_s;

    // Shared period counter; holds between ticks and is cleared outside RUN.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!(running_s && timer_En)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    // Period shadow accepts writes at any time.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            period_sh_r <= {CNT_W{1'b0}};
        end else if (period_wr) begin
            period_sh_r <= period_data;
        end
    end

    // Active period reloads together with the duties.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            period_act_r <= {CNT_W{1'b0}};
        end else if (reload_s) begin
            period_act_r <= period_sh_r;
        end
    end

    // Wrap pulse lines up with the counter returning to zero.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            period_done_r <= 1'b0;
        end else begin
            period_done_r <= wrap_s;
        end
    end

    assign period_done = period_done_r;
    assign cnt_value   = cnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .ref_clk   (ref_clk),
            .rst       (rst),
            .duty_wr   (duty_wr[g]),
            .duty_data (duty_data),
            .reload    (reload_s),
            .running   (running_s),
            .cnt       (cnt_r),
            .ch_en     (ch_En[g]),
            .polarity  (polarity[g]),
            .pwm_out   (pwm_out[g])
        );
    end

endmodule
